uart_rx: RTL and testbench
==========================

# uart_rx

- UART receive path for the wave generator's host link.
- Takes the asynchronous serial input `rxd_i` and generates its own 16x-oversample enable from the system clock.
- Frames 8N1 characters (LSB first) with a mid-bit sampling state machine.
- Presents each received byte as a one-cycle valid pulse to the command parser. Line errors are flagged, not corrected.

## Interface

Parameters:
- `BAUD_RATE`, 9600: serial bit rate in bits/s.
- `CLOCK_RATE`, 100_000_000: `clk_rx` frequency in Hz.
- Derived `OVERSAMPLE_DIV` = round(CLOCK_RATE / (BAUD_RATE*16)); 651 at defaults. Must be ≥ 2.

Ports:
- `clk_rx` input 1: receive clock, the only clock in the block.
- `rst_clk_rx` input 1: active-HIGH reset, synchronous to `clk_rx`.
- `rxd_i` input 1: serial line, asynchronous, idle high.
- `rx_data` output 8: last received character.
- `rx_data_rdy` output 1: one-cycle pulse; `rx_data` holds a new valid character.
- `frm_err` output 1: one-cycle pulse; stop bit sampled low.
- `par_err` output 1: one-cycle pulse; parity mismatch. Constant 0 unless parity is compiled in.

## Operation

- **Synchronizer:** 2-flop synchronizer on `rxd_i` produces `rxd_s`. Both flops reset to 1.
- **Oversample counter:** `os_cnt` counts 0..OVERSAMPLE_DIV-1 and wraps. `baud_x16_en` is high for the single cycle where `os_cnt == OVERSAMPLE_DIV-1`. Counter width is clog2(OVERSAMPLE_DIV).
- **Gating:** All FSM, sample-counter and bit-counter updates occur only in cycles where `baud_x16_en` = 1.
- **Counters:** 4-bit sample counter `smp_cnt`; 3-bit bit counter `bit_cnt`.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP.
- **IDLE:** `rxd_s` = 0 → START, `smp_cnt` ← 0.
- **START:** `smp_cnt` increments. At `smp_cnt` = 7 (mid start bit):
  - `rxd_s` = 0 → DATA, `smp_cnt` ← 0, `bit_cnt` ← 0.
  - `rxd_s` = 1 → IDLE (glitch rejected, no output).
- **DATA:** at `smp_cnt` = 15, shift `rxd_s` into `shreg[7]` with a right shift, so the LSB arrives first. `bit_cnt` increments; `smp_cnt` wraps to 0. After the sample with `bit_cnt` = 7 → PARITY if the macro is defined, else STOP.
- **PARITY:** at `smp_cnt` = 15, capture `rxd_s` as `par_bit` → STOP.
- **STOP:** at `smp_cnt` = 15:
  - `rx_data` ← `shreg` in all cases.
  - `rxd_s` = 1 → pulse `rx_data_rdy`.
  - `rxd_s` = 0 → pulse `frm_err`, no `rx_data_rdy`.
  - Always → IDLE.
- **Break:** a held-low line after a framing error is treated as a new start bit. A break condition therefore produces repeated `frm_err` pulses.
- **Reset values:** `rx_data` = 0x00; `rx_data_rdy`, `frm_err`, `par_err` = 0; FSM = IDLE; `os_cnt`, `smp_cnt`, `bit_cnt`, `shreg` = 0.
- **Reset mid-frame:** the partial character is discarded with no pulse. The next falling edge after reset release starts a fresh frame.

## Timing

- **Output registration:** all outputs are registered. Pulses assert on the clock edge following the `baud_x16_en` cycle that samples the stop bit, and last exactly one `clk_rx` cycle.
- **Pulse spacing:** `rx_data_rdy` and `frm_err` are mutually exclusive. `par_err` may coincide with either.
- **`rx_data` hold:** `rx_data` changes only on that same edge and holds until the next completed frame.
- **Latency:** 2 `clk_rx` cycles (synchronizer) plus up to 1 oversample tick (falling-edge detection). Stop-bit sample to pulse is 1 `clk_rx` cycle.
- **No back-pressure:** the consumer must accept the pulse. Minimum spacing between `rx_data_rdy` pulses is 160·OVERSAMPLE_DIV cycles for 8N1, 176·OVERSAMPLE_DIV with parity.
- **Baud tolerance:** sampling at ticks 8 and 24, 40, … from the falling edge tolerates ±4% cumulative baud mismatch.

## Configuration

- **`UART_RX_PARITY_EN` defined:**
  - Frame is 8E1 and the PARITY state exists.
  - In STOP, `par_err` pulses when (^`shreg`) ^ `par_bit` = 1, independent of the stop-bit result.
- **Not defined:**
  - Frame is 8N1 and the PARITY state is not synthesized.
  - `par_err` is tied to 0.

## Test plan

Bench parameters: CLOCK_RATE = 1_600_000, BAUD_RATE = 10_000, so OVERSAMPLE_DIV = 10 and one bit = 160 clocks.

- **Valid 8N1 frame:** send 0xA5 → exactly one `rx_data_rdy` pulse with `rx_data` = 0xA5 and `frm_err` = 0. The pulse occurs about 1528 cycles (9.5 bit periods) after the start edge, ±12.
- **Back-to-back frames:** send 0x00, 0xFF, 0x55 with no idle gap → three pulses in order with the correct bytes; no errors.
- **Start glitch:** drive `rxd_i` low for 40 clocks, then high → no pulse; FSM returns to IDLE. Then send 0x3C → received correctly.
- **Framing error:** send 0x81 with the stop bit forced low → one `frm_err` pulse; no `rx_data_rdy`; `rx_data` = 0x81.
- **Reset mid-frame:** assert `rst_clk_rx` for 1 cycle during bit 4 of 0x7E → all outputs 0 with no pulses. A subsequent 0x12 is received correctly.
- **Parity (`UART_RX_PARITY_EN` defined):** send 0x07 with parity bit 1 → `rx_data_rdy` only. Send 0x07 with parity bit 0 → `rx_data_rdy` and `par_err` pulse in the same cycle.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side result bus from uart_rx to the command parser.
//   rx_data     [7:0] last received character
//   rx_data_rdy       one-cycle pulse, rx_data holds a new valid character
//   frm_err           one-cycle pulse, stop bit sampled low
//   par_err           one-cycle pulse, parity mismatch (0 when parity not built)
// Modports: master = uart_rx (drives), slave = consumer (samples).
interface uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       frm_err;
    logic       par_err;

    modport master (
        output rx_data,
        output rx_data_rdy,
        output frm_err,
        output par_err
    );

    modport slave (
        input rx_data,
        input rx_data_rdy,
        input frm_err,
        input par_err
    );

endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receive path for the wave generator host link.
// Synchronizes rxd_i, derives a 16x oversample enable from clk_rx and frames
// 8N1 characters (LSB first) with mid-bit sampling. Each completed frame
// produces a one-cycle rx_data_rdy or frm_err pulse; errors are only flagged.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit, 8E1).
// Ports:
//   clk_rx      in   receive clock, only clock in the block
//   rst_clk_rx  in   active-high reset, synchronous to clk_rx
//   rxd_i       in   asynchronous serial line, idle high
//   rx_bus      master modport of uart_rx_if (rx_data/rx_data_rdy/frm_err/par_err)
// Parameters: BAUD_RATE (bit/s), CLOCK_RATE (Hz); the rounded oversample
// divider CLOCK_RATE/(16*BAUD_RATE) must come out at 2 or more.
module uart_rx #(
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned CLOCK_RATE = 100_000_000
) (
    input  logic       clk_rx,
    input  logic       rst_clk_rx,
    input  logic       rxd_i,
    uart_rx_if.master  rx_bus
);

    localparam int unsigned OVERSAMPLE_DIV = (CLOCK_RATE + BAUD_RATE * 8) / (BAUD_RATE * 16);
    localparam int unsigned OS_W           = (OVERSAMPLE_DIV > 1) ? $clog2(OVERSAMPLE_DIV) : 1;
    localparam int unsigned SMP_W          = 4;
    localparam int unsigned BIT_W          = 3;
    localparam int unsigned DATA_W         = 8;

    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(7);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(15);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    logic              rxd_meta;
    logic              rxd_s;
    logic [OS_W-1:0]   os_cnt;
    logic              baud_x16_en;

    logic [2:0]        state,     state_nxt;
    logic [SMP_W-1:0]  smp_cnt,   smp_cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt,   bit_cnt_nxt;
    logic [DATA_W-1:0] shreg,     shreg_nxt;
    logic [DATA_W-1:0] rx_data_q, rx_data_nxt;
    logic              rdy_q,     rdy_nxt;
    logic              frm_q,     frm_nxt;
`ifdef UART_RX_PARITY_EN
    logic              par_bit,   par_bit_nxt;
    logic              par_q,     par_nxt;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd_i;
            rxd_s    <= rxd_meta;
        end
    end

    // Free-running oversample divider; enable is the terminal-count cycle.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            os_cnt <= '0;
        end else if (os_cnt == OS_LAST) begin
            os_cnt <= '0;
        end else begin
            os_cnt <= os_cnt + OS_W'(1);
        end
    end

    assign baud_x16_en = (os_cnt == OS_LAST);

    // State and datapath registers.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            state     <= ST_IDLE;
            smp_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            frm_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            par_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            smp_cnt   <= smp_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            rx_data_q <= rx_data_nxt;
            rdy_q     <= rdy_nxt;
            frm_q     <= frm_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit   <= par_bit_nxt;
            par_q     <= par_nxt;
`endif
        end
    end

    // Next-state and output decode; everything advances only on oversample ticks.
    always_comb begin
        state_nxt   = state;
        smp_cnt_nxt = smp_cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        rx_data_nxt = rx_data_q;
        rdy_nxt     = 1'b0;
        frm_nxt     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit;
        par_nxt     = 1'b0;
`endif

        if (baud_x16_en) begin
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_nxt   = ST_START;
                        smp_cnt_nxt = '0;
                    end
                end

                ST_START: begin
                    // Re-check the line half a bit in so short glitches are dropped.
                    if (smp_cnt == SMP_MID) begin
                        if (!rxd_s) begin
                            state_nxt   = ST_DATA;
                            smp_cnt_nxt = '0;
                            bit_cnt_nxt = '0;
                        end else begin
                            state_nxt   = ST_IDLE;
                        end
                    end else begin
                        smp_cnt_nxt = smp_cnt + SMP_W'(1);
                    end
                end

                ST_DATA: begin
                    if (smp_cnt == SMP_LAST) begin
                        // Right shift: first (LSB) bit ends up in shreg[0].
                        shreg_nxt   = {rxd_s, shreg[DATA_W-1:1]};
                        smp_cnt_nxt = '0;
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = ST_PARITY;
`else
                            state_nxt = ST_STOP;
`endif
                        end
                    end else begin
                        smp_cnt_nxt = smp_cnt + SMP_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (smp_cnt == SMP_LAST) begin
                        par_bit_nxt = rxd_s;
                        smp_cnt_nxt = '0;
                        state_nxt   = ST_STOP;
                    end else begin
                        smp_cnt_nxt = smp_cnt + SMP_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (smp_cnt == SMP_LAST) begin
                        // Character is published even on a framing error.
                        rx_data_nxt = shreg;
                        rdy_nxt     = rxd_s;
                        frm_nxt     = !rxd_s;
`ifdef UART_RX_PARITY_EN
                        par_nxt     = (^shreg) ^ par_bit;
`endif
                        smp_cnt_nxt = '0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        smp_cnt_nxt = smp_cnt + SMP_W'(1);
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign rx_bus.rx_data     = rx_data_q;
    assign rx_bus.rx_data_rdy = rdy_q;
    assign rx_bus.frm_err     = frm_q;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.par_err     = par_q;
`else
    assign rx_bus.par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx.
// Frames are generated bit-by-bit from the serial protocol; every frame
// pushes its expected result (byte, ok/framing error, parity error) onto a
// queue that a negedge monitor pops whenever the DUT pulses.
module tb_uart_rx;

    localparam int unsigned CLOCK_RATE = 1_600_000;
    localparam int unsigned BAUD_RATE  = 10_000;
    localparam int          BIT_CLKS   = 160;
`ifdef UART_RX_PARITY_EN
    localparam bit          PAR_EN     = 1'b1;
`else
    localparam bit          PAR_EN     = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       rdy;
        logic       frm;
        logic       par;
    } exp_t;

    logic clk_rx;
    logic rst_clk_rx;
    logic rxd_i;

    uart_rx_if rx_bus ();

    uart_rx #(
        .BAUD_RATE  (BAUD_RATE),
        .CLOCK_RATE (CLOCK_RATE)
    ) dut (
        .clk_rx     (clk_rx),
        .rst_clk_rx (rst_clk_rx),
        .rxd_i      (rxd_i),
        .rx_bus     (rx_bus)
    );

    initial clk_rx = 1'b0;
    always #5 clk_rx = ~clk_rx;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_evt    = 0;
    int   cyc      = 0;
    int   last_evt_cyc = 0;
    int   frame_start_cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always @(posedge clk_rx) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every pulse must match the oldest outstanding frame.
    always @(negedge clk_rx) begin
        if (!rst_clk_rx && (rx_bus.rx_data_rdy || rx_bus.frm_err || rx_bus.par_err)) begin
            n_evt++;
            last_evt_cyc = cyc;
            check_val("rdy_frm_excl", 32'(rx_bus.rx_data_rdy & rx_bus.frm_err), 32'd0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse",
                          32'({rx_bus.rx_data_rdy, rx_bus.frm_err, rx_bus.par_err}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("rx_data", 32'(rx_bus.rx_data),     32'(mon_e.data));
                check_val("rdy",     32'(rx_bus.rx_data_rdy), 32'(mon_e.rdy));
                check_val("frm_err", 32'(rx_bus.frm_err),     32'(mon_e.frm));
                check_val("par_err", 32'(rx_bus.par_err),     32'(mon_e.par));
            end
        end
    end

    task automatic drive_bit(input logic b, input int clks);
        rxd_i = b;
        repeat (clks) @(posedge clk_rx);
        #1;
    endtask

    // One serial frame followed by gap_bits of idle line.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_bit, input int gap_bits);
        exp_t e;
        e.data = data;
        e.rdy  = stop_bit;
        e.frm  = !stop_bit;
        e.par  = PAR_EN ? ((^data) ^ par_bit) : 1'b0;
        exp_q.push_back(e);
        frame_start_cyc = cyc;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_CLKS);
        if (PAR_EN) drive_bit(par_bit, BIT_CLKS);
        drive_bit(stop_bit, BIT_CLKS);
        rxd_i = 1'b1;
        if (gap_bits > 0) drive_bit(1'b1, gap_bits * BIT_CLKS);
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    initial begin
        int lat;
        int evt_before;
        logic [7:0] d;
        logic       stop;
        logic       pb;

        rxd_i      = 1'b1;
        rst_clk_rx = 1'b1;
        repeat (4) @(posedge clk_rx);
        #1;
        rst_clk_rx = 1'b0;
        @(negedge clk_rx);
        check_val("reset_rx_data", 32'(rx_bus.rx_data),     32'd0);
        check_val("reset_rdy",     32'(rx_bus.rx_data_rdy), 32'd0);
        check_val("reset_frm",     32'(rx_bus.frm_err),     32'd0);
        check_val("reset_par",     32'(rx_bus.par_err),     32'd0);
        drive_bit(1'b1, 2 * BIT_CLKS);

        // Valid frame and start-edge to pulse latency (~9.5 bit periods).
        evt_before = n_evt;
        send_frame(8'hA5, 1'b1, even_par(8'hA5), 2);
        lat = last_evt_cyc - frame_start_cyc;
        check_val("a5_pulse_count", 32'(n_evt - evt_before), 32'd1);
        check_val("a5_latency_ok", 32'((lat >= 1516) && (lat <= 1540)), 32'd1);

        // Back-to-back frames, no idle between stop and next start.
        send_frame(8'h00, 1'b1, even_par(8'h00), 0);
        send_frame(8'hFF, 1'b1, even_par(8'hFF), 0);
        send_frame(8'h55, 1'b1, even_par(8'h55), 2);
        check_val("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Start glitch shorter than half a bit is rejected.
        evt_before = n_evt;
        drive_bit(1'b0, 40);
        drive_bit(1'b1, 3 * BIT_CLKS);
        check_val("glitch_no_pulse", 32'(n_evt - evt_before), 32'd0);
        send_frame(8'h3C, 1'b1, even_par(8'h3C), 2);

        // Framing error: stop bit low still publishes the byte.
        send_frame(8'h81, 1'b0, even_par(8'h81), 3);
        check_val("frm_rx_data_hold", 32'(rx_bus.rx_data), 32'h81);

        // Reset during bit 4 of 0x7E discards the partial character.
        evt_before = n_evt;
        d = 8'h7E;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
        drive_bit(d[4], BIT_CLKS / 2);
        rst_clk_rx = 1'b1;
        @(posedge clk_rx);
        #1;
        rst_clk_rx = 1'b0;
        rxd_i      = 1'b1;
        @(negedge clk_rx);
        check_val("midrst_rx_data", 32'(rx_bus.rx_data),     32'd0);
        check_val("midrst_rdy",     32'(rx_bus.rx_data_rdy), 32'd0);
        check_val("midrst_frm",     32'(rx_bus.frm_err),     32'd0);
        drive_bit(1'b1, 12 * BIT_CLKS);
        check_val("midrst_no_pulse", 32'(n_evt - evt_before), 32'd0);
        send_frame(8'h12, 1'b1, even_par(8'h12), 2);

        if (PAR_EN) begin
            // 0x07 has odd weight, so even parity needs a 1 in the parity slot.
            send_frame(8'h07, 1'b1, 1'b1, 2);
            send_frame(8'h07, 1'b1, 1'b0, 2);
        end

        // Randomized frames: occasional framing errors and random parity bits.
        for (int k = 0; k < 12; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pb   = 1'($urandom_range(0, 1));
            send_frame(d, stop, pb, stop ? int'($urandom_range(0, 2)) : 3);
        end

        drive_bit(1'b1, 3 * BIT_CLKS);
        check_val("final_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
